uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_cnt.sv | 35 +++
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, idle line level and baud divisor helper.
// Used by both uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Truncating division, so odd clock/baud ratios round the bit time down.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last clock of each bit.
// Held at zero by clr so every frame starts on a fresh bit boundary.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_end
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign bit_end = (cnt_q == 32'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding buffer so the next byte queues while the
// current frame shifts out; frames run back-to-back, LSB first, idle-high line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  cnt_bit_q, cnt_bit_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        stop_last;
  logic        accept;
  logic        load;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .en     (state_q != S_IDLE),
    .clr    (state_q == S_IDLE),
    .bit_end(bit_end)
  );

  assign stop_last = (cnt_bit_q == 4'(STOP_BITS - 1));
  assign accept    = tx_vld && !hold_full_q;
  assign tx_rdy    = !hold_full_q;
  assign tx        = tx_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      cnt_bit_q   <= '0;
      tx_q        <= LINE_IDLE;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      cnt_bit_q   <= cnt_bit_d;
      tx_q        <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_bit_d = cnt_bit_q;
    shift_d   = shift_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          cnt_bit_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (cnt_bit_q == 4'(DATA_BITS - 1)) begin
            state_d   = S_STOP;
            cnt_bit_d = '0;
          end else begin
            cnt_bit_d = cnt_bit_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_last) begin
            cnt_bit_d = '0;
            // A queued byte starts on the very next clock, leaving no idle gap.
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_bit_d = cnt_bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      shift_d = hold_q;
    end
    hold_d      = accept ? tx_data : hold_q;
    hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
  end

  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = LINE_IDLE;
    endcase
    tx_busy = (state_q != S_IDLE);
    tx_done = (state_q == S_STOP) && bit_end && stop_last;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a frame-level line model compared every clock on an
// 8N2 instance (10 clocks per bit) plus a vector table on a 5N1 instance (8 clocks per bit).
module tb_uart_tx;

  localparam int CPB = 10;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_rdy, tx, tx_busy, tx_done;
  logic [7:0] tx_data6;
  logic       tx_vld6;
  logic       tx_rdy6, tx6, tx_busy6, tx_done6;

  always #5 sys_clk = ~sys_clk;

  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(99), .DATA_BITS(8), .STOP_BITS(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data), .tx_vld(tx_vld),
    .tx_rdy(tx_rdy), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_BITS(5), .STOP_BITS(1)) dut6 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(tx_data6), .tx_vld(tx_vld6),
    .tx_rdy(tx_rdy6), .tx(tx6), .tx_busy(tx_busy6), .tx_done(tx_done6)
  );

  typedef struct {
    bit lvl;
    bit last;
  } slot_t;

  typedef struct {
    logic [7:0] data;
    logic [6:0] frame;
  } vec6_t;

  slot_t      expQ[$];
  logic [7:0] pendQ[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         doneCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected line levels for one whole frame, one entry per clock.
  task automatic pushFrame(input logic [7:0] b);
    logic [10:0] bits;
    bits = {2'b11, b, 1'b0};
    for (int i = 0; i < 11; i++)
      for (int k = 0; k < CPB; k++)
        expQ.push_back('{bits[i], (i == 10 && k == CPB - 1)});
  endtask

  // One clock of stimulus on the 8N2 instance, then compare tx/busy/done/rdy with the model.
  task automatic applyStimulus(input bit vld, input logic [7:0] data);
    slot_t      s;
    bit         have;
    bit         acc;
    logic [3:0] expv;
    tx_vld  = vld;
    tx_data = data;
    acc = vld && (pendQ.size() == 0);
    @(posedge sys_clk);
    #1;
    cyc++;
    have = 1'b0;
    s = '{1'b1, 1'b0};
    if (expQ.size() == 0 && pendQ.size() > 0) pushFrame(pendQ.pop_front());
    if (expQ.size() > 0) begin
      s = expQ.pop_front();
      have = 1'b1;
    end
    if (acc) pendQ.push_back(data);
    expv = {s.lvl, have, have && s.last, pendQ.size() == 0};
    if (tx_done) doneCount++;
    checkOutput($sformatf("line@%0d", cyc), {28'd0, tx, tx_busy, tx_done, tx_rdy}, {28'd0, expv});
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'($urandom));
  endtask

  // Hold tx_vld until the byte is taken; toggle scrambles tx_data while the buffer is full.
  task automatic sendByte(input logic [7:0] b, input bit toggle);
    int guard;
    bit acc;
    guard = 0;
    do begin
      acc = (pendQ.size() == 0);
      applyStimulus(1'b1, (toggle && !acc) ? 8'($urandom) : b);
      guard++;
    end while (!acc && guard < 1000);
    checkOutput("send_accept", {31'd0, acc}, 32'd1);
  endtask

  initial begin
    vec6_t      vecs[4];
    logic [69:0] line6;
    int         doneAt, doneCnt6, busyCnt6;

    vecs[0] = '{8'h13, 7'b1100110};
    vecs[1] = '{8'hE0, 7'b1000000};
    vecs[2] = '{8'h0A, 7'b1010100};
    vecs[3] = '{8'h3F, 7'b1111110};

    sys_rst = 1'b1;
    tx_vld = 1'b0;
    tx_data = 8'h00;
    tx_vld6 = 1'b0;
    tx_data6 = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_rdy", {31'd0, tx_rdy}, 32'd1);
    checkOutput("reset_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset_done", {31'd0, tx_done}, 32'd0);
    checkOutput("reset_tx6", {31'd0, tx6}, 32'd1);
    sys_rst = 1'b0;

    // Single byte from idle.
    applyStimulus(1'b1, 8'h55);
    idle(130);

    // Back-to-back with tx_vld held high across both bytes.
    sendByte(8'hA5, 1'b0);
    sendByte(8'h3C, 1'b0);
    idle(240);

    // Stall with tx_data scrambled every clock while not ready.
    sendByte(8'hC3, 1'b1);
    sendByte(8'h7E, 1'b1);
    sendByte(8'h81, 1'b1);
    idle(350);

    // Reset mid data phase with a byte buffered.
    sendByte(8'hF0, 1'b0);
    sendByte(8'h0F, 1'b0);
    idle(3 * CPB);
    sys_rst = 1'b1;
    #1;
    checkOutput("midreset_tx", {31'd0, tx}, 32'd1);
    checkOutput("midreset_rdy", {31'd0, tx_rdy}, 32'd1);
    checkOutput("midreset_busy", {31'd0, tx_busy}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    expQ.delete();
    pendQ.delete();
    idle(300);

    // Every byte value back-to-back.
    doneCount = 0;
    for (int b = 0; b < 256; b++) sendByte(8'(b), 1'b0);
    idle(240);
    checkOutput("done_count_256", 32'(doneCount), 32'd256);

    // Random bytes with random gaps and random stalls.
    for (int i = 0; i < 40; i++) begin
      sendByte(8'($urandom), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 30));
    end
    idle(240);

    // 5N1 table: frame bits listed first-transmitted in bit 0.
    tx_vld = 1'b0;
    for (int v = 0; v < 4; v++) begin
      doneAt = -1;
      doneCnt6 = 0;
      busyCnt6 = 0;
      tx_data6 = vecs[v].data;
      tx_vld6 = 1'b1;
      @(posedge sys_clk);
      #1;
      tx_vld6 = 1'b0;
      tx_data6 = 8'($urandom);
      for (int c = 0; c < 70; c++) begin
        @(posedge sys_clk);
        #1;
        line6[c] = tx6;
        if (tx_done6) begin
          doneAt = c;
          doneCnt6++;
        end
        if (tx_busy6) busyCnt6++;
      end
      for (int b = 0; b < 7; b++)
        checkOutput($sformatf("t6_v%0d_bit%0d", v, b), {24'd0, line6[b*8 +: 8]},
                    {24'd0, {8{vecs[v].frame[b]}}});
      checkOutput($sformatf("t6_v%0d_idle", v), {18'd0, line6[69:56]}, {18'd0, 14'h3FFF});
      checkOutput($sformatf("t6_v%0d_done_at", v), 32'(doneAt), 32'd55);
      checkOutput($sformatf("t6_v%0d_done_cnt", v), 32'(doneCnt6), 32'd1);
      checkOutput($sformatf("t6_v%0d_busy_len", v), 32'(busyCnt6), 32'd56);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
